// File: rtl/axi4_master_bridge_pkg.sv
// Shared AXI4 constants and FSM state encodings for the arbiter-to-AXI4 master bridge.
package axi4_master_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_ID_DEFAULT = 4'd0;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_e;

endpackage

// File: rtl/axi4_wr_align.sv
// Moves LSB-aligned write data and byte mask onto the bus byte lanes selected by the address.
module axi4_wr_align #(
  parameter int XLEN   = 32,
  parameter int STRB_W = XLEN / 8
) (
  input  logic [1:0]        off_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [3:0]        wmask_i,
  output logic [XLEN-1:0]   wdata_o,
  output logic [STRB_W-1:0] wstrb_o
);

  logic [STRB_W+3:0] strb_ext;

  always_comb begin
    wdata_o  = wdata_i << {off_i, 3'b000};
    // Widen before shifting so mask bits pushed past the top lane are dropped, not wrapped.
    strb_ext = {{STRB_W{1'b0}}, wmask_i} << off_i;
    wstrb_o  = strb_ext[STRB_W-1:0];
  end

endmodule

// File: rtl/axi4_master_bridge.sv
// Converts the arbiter's single-requester read/write ports into AXI4 master channels.
// Read and write FSMs are independent and run concurrently; ID 0, INCR bursts only.
module axi4_master_bridge
  import axi4_master_bridge_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   arb_read_addr_i,
  input  logic              arb_raddr_valid_i,
  input  logic [3:0]        arb_rsize_i,
  input  logic [7:0]        arb_rlen_i,
  output logic [XLEN-1:0]   arb_rdata_o,
  output logic              arb_rdata_ready_o,
  output logic              arb_rlast_o,
  input  logic [XLEN-1:0]   arb_write_addr_i,
  input  logic              arb_write_valid_i,
  input  logic [3:0]        arb_wmask_i,
  input  logic [XLEN-1:0]   arb_wdata_i,
  input  logic [3:0]        arb_wsize_i,
  output logic              arb_wdata_ready_o,
  output logic              resp_err_o,
  output logic [XLEN-1:0]   araddr,
  output logic              arvalid,
  input  logic              arready,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [3:0]        arid,
  input  logic [XLEN-1:0]   rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  input  logic [3:0]        rid,
  output logic [XLEN-1:0]   awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [3:0]        awid,
  output logic [XLEN-1:0]   wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  input  logic [3:0]        bid
);

  rstate_e           r_state_q, r_state_d;
  logic [XLEN-1:0]   araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [2:0]        arsize_q, arsize_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;

  wstate_e           w_state_q, w_state_d;
  logic [XLEN-1:0]   awaddr_q, awaddr_d;
  logic [2:0]        awsize_q, awsize_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;

  logic              err_q, err_d;

  logic              r_beat, r_last, r_err;
  logic              b_done, w_err;
  logic [XLEN-1:0]   wdata_al;
  logic [STRB_W-1:0] wstrb_al;

  // IDs are fixed at zero, so response IDs carry no information; top size bit is unused.
  logic unused_ok;
  assign unused_ok = ^{rid, bid, arb_rsize_i[3], arb_wsize_i[3]};

  axi4_wr_align #(.XLEN(XLEN), .STRB_W(STRB_W)) u_align (
    .off_i   (arb_write_addr_i[1:0]),
    .wdata_i (arb_wdata_i),
    .wmask_i (arb_wmask_i),
    .wdata_o (wdata_al),
    .wstrb_o (wstrb_al)
  );

  always_comb begin
    r_state_d  = r_state_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arsize_d   = arsize_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    beat_cnt_d = beat_cnt_q;
    r_beat     = 1'b0;
    r_last     = 1'b0;
    r_err      = 1'b0;
    case (r_state_q)
      R_IDLE: if (arb_raddr_valid_i) begin
        araddr_d   = arb_read_addr_i;
        arlen_d    = arb_rlen_i;
        arsize_d   = arb_rsize_i[2:0];
        arvalid_d  = 1'b1;
        beat_cnt_d = 8'd0;
        r_state_d  = R_ADDR;
      end
      R_ADDR: if (arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        r_beat = rvalid & rready_q;
        if (r_beat) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // Burst ends at the earlier of slave rlast and our own count; disagreement is an error.
          r_err = (rresp != AXI_RESP_OKAY) | (rlast != (beat_cnt_q == arlen_q));
          if (rlast || beat_cnt_q == arlen_q) begin
            r_last    = 1'b1;
            rready_d  = 1'b0;
            r_state_d = R_IDLE;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    b_done    = 1'b0;
    w_err     = 1'b0;
    case (w_state_q)
      W_IDLE: if (arb_write_valid_i) begin
        awaddr_d  = arb_write_addr_i;
        awsize_d  = arb_wsize_i[2:0];
        wdata_d   = wdata_al;
        wstrb_d   = wstrb_al;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        w_state_d = W_SEND;
      end
      W_SEND: begin
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d  = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        b_done = bvalid & bready_q;
        if (b_done) begin
          w_err     = (bresp != AXI_RESP_OKAY);
          bready_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    err_d = err_q | r_err | w_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q  <= R_IDLE;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      beat_cnt_q <= '0;
      w_state_q  <= W_IDLE;
      awaddr_q   <= '0;
      awsize_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arsize_q   <= arsize_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      beat_cnt_q <= beat_cnt_d;
      w_state_q  <= w_state_d;
      awaddr_q   <= awaddr_d;
      awsize_q   <= awsize_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      err_q      <= err_d;
    end
  end

  assign arb_rdata_o       = r_beat ? rdata : '0;
  assign arb_rdata_ready_o = r_beat;
  assign arb_rlast_o       = r_last;
  assign arb_wdata_ready_o = b_done;
  assign resp_err_o        = err_q;

  assign araddr  = araddr_q;
  assign arvalid = arvalid_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;
  assign arburst = AXI_BURST_INCR;
  assign arid    = AXI_ID_DEFAULT;
  assign rready  = rready_q;

  assign awaddr  = awaddr_q;
  assign awvalid = awvalid_q;
  assign awlen   = 8'd0;
  assign awsize  = awsize_q;
  assign awburst = AXI_BURST_INCR;
  assign awid    = AXI_ID_DEFAULT;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = wvalid_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule

// File: tb/tb_axi4_master_bridge.sv
// Bench for axi4_master_bridge: configurable AXI slave, write-alignment vector table,
// directed corner cases and randomized traffic against a byte-lane reference model.
module tb_axi4_master_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] arb_read_addr_i = '0, arb_write_addr_i = '0, arb_wdata_i = '0;
  logic        arb_raddr_valid_i = 1'b0, arb_write_valid_i = 1'b0;
  logic [3:0]  arb_rsize_i = '0, arb_wmask_i = '0, arb_wsize_i = '0;
  logic [7:0]  arb_rlen_i = '0;
  logic [31:0] arb_rdata_o;
  logic        arb_rdata_ready_o, arb_rlast_o, arb_wdata_ready_o, resp_err_o;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rready, rvalid, rlast, awvalid, awready, wvalid, wready, wlast;
  logic        bvalid, bready;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic [3:0]  arid, awid, wstrb;
  logic [3:0]  rid = '0, bid = '0;

  axi4_master_bridge #(.XLEN(32), .STRB_W(4)) dut (
    .clk(clk), .rst(rst),
    .arb_read_addr_i(arb_read_addr_i), .arb_raddr_valid_i(arb_raddr_valid_i),
    .arb_rsize_i(arb_rsize_i), .arb_rlen_i(arb_rlen_i),
    .arb_rdata_o(arb_rdata_o), .arb_rdata_ready_o(arb_rdata_ready_o), .arb_rlast_o(arb_rlast_o),
    .arb_write_addr_i(arb_write_addr_i), .arb_write_valid_i(arb_write_valid_i),
    .arb_wmask_i(arb_wmask_i), .arb_wdata_i(arb_wdata_i), .arb_wsize_i(arb_wsize_i),
    .arb_wdata_ready_o(arb_wdata_ready_o), .resp_err_o(resp_err_o),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arid(arid),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready), .rid(rid),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awid(awid),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .bid(bid)
  );

  // Slave knobs, set by the main sequence.
  int          ar_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0, r_gap_pct = 0, rlast_off = 0;
  logic [31:0] rbase = '0;
  logic [1:0]  rresp_val = '0, bresp_val = '0;

  int          ar_wait, aw_wait, w_wait, b_wait, r_beat;
  logic [7:0]  r_len;
  bit          r_pend, aw_got, w_got;
  int          b_hs = 0;
  logic [31:0] cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic [2:0]  cap_awsize;
  logic [7:0]  cap_awlen;
  logic        cap_wlast;

  assign arready = arvalid && (ar_wait >= ar_lat);
  assign awready = awvalid && (aw_wait >= aw_lat);
  assign wready  = wvalid && (w_wait >= w_lat);

  function automatic bit rnd_valid();
    return $urandom_range(0, 99) >= r_gap_pct;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ar_wait <= 0; aw_wait <= 0; w_wait <= 0; b_wait <= 0; r_beat <= 0; r_len <= '0;
      r_pend <= 0; aw_got <= 0; w_got <= 0;
      rvalid <= 0; rlast <= 0; rdata <= '0; rresp <= '0; bvalid <= 0; bresp <= '0;
    end else begin
      if (arvalid && arready) begin
        ar_wait <= 0; r_pend <= 1; r_len <= arlen; r_beat <= 0;
        rvalid <= rnd_valid(); rdata <= rbase; rresp <= rresp_val;
        rlast <= (0 == int'(arlen) + rlast_off);
      end else begin
        if (arvalid) ar_wait <= ar_wait + 1;
        if (r_pend) begin
          if (rvalid && rready) begin
            if (rlast) begin
              r_pend <= 0; rvalid <= 0; rlast <= 0;
            end else begin
              r_beat <= r_beat + 1; rvalid <= rnd_valid();
              rdata  <= rbase + 32'(r_beat + 1);
              rlast  <= (r_beat + 1 == int'(r_len) + rlast_off);
            end
          end else if (!rvalid) begin
            rvalid <= rnd_valid();
          end
        end
      end
      if (bvalid && bready) begin
        bvalid <= 0; aw_got <= 0; w_got <= 0; b_wait <= 0; b_hs <= b_hs + 1;
      end else if (aw_got && w_got && !bvalid) begin
        if (b_wait >= b_lat) begin bvalid <= 1; bresp <= bresp_val; end
        else b_wait <= b_wait + 1;
      end
      if (awvalid && awready) begin
        aw_wait <= 0; aw_got <= 1; cap_awaddr <= awaddr; cap_awsize <= awsize; cap_awlen <= awlen;
      end else if (awvalid) aw_wait <= aw_wait + 1;
      if (wvalid && wready) begin
        w_wait <= 0; w_got <= 1; cap_wdata <= wdata; cap_wstrb <= wstrb; cap_wlast <= wlast;
      end else if (wvalid) w_wait <= w_wait + 1;
    end
  end

  // AR stability / hold-time monitor and write completion pulse counter.
  int          ar_vcyc = 0, ar_unstable = 0, wr_pulse_cnt = 0;
  logic        pv = 0, phs = 0;
  logic [31:0] pa, hs_araddr;
  logic [7:0]  pl, hs_arlen;
  logic [2:0]  ps, hs_arsize;

  always @(negedge clk) begin
    if (rst) begin
      pv <= 0; phs <= 0;
    end else begin
      if (arvalid) ar_vcyc <= ar_vcyc + 1;
      if (pv && !phs && (!arvalid || araddr != pa || arlen != pl || arsize != ps))
        ar_unstable <= ar_unstable + 1;
      pv <= arvalid; phs <= arvalid && arready; pa <= araddr; pl <= arlen; ps <= arsize;
      if (arvalid && arready) begin hs_araddr <= araddr; hs_arlen <= arlen; hs_arsize <= arsize; end
      if (arb_wdata_ready_o) wr_pulse_cnt <= wr_pulse_cnt + 1;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [31:0] rd_buf [0:255];
  int          rd_n, rd_last_at;
  bit          rd_done, wr_done;

  task automatic do_read(input logic [31:0] a, input logic [7:0] len);
    @(posedge clk); #1;
    arb_read_addr_i = a; arb_rlen_i = len; arb_rsize_i = 4'd2; arb_raddr_valid_i = 1'b1;
    rd_n = 0; rd_last_at = -1; rd_done = 0;
    for (int c = 0; c < 400 && !rd_done; c++) begin
      @(negedge clk);
      if (arb_rdata_ready_o) begin
        rd_buf[rd_n] = arb_rdata_o;
        if (arb_rlast_o) rd_last_at = rd_n;
        rd_n++;
      end
      if (arb_rlast_o) rd_done = 1;
    end
    @(posedge clk); #1;
    arb_raddr_valid_i = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    @(posedge clk); #1;
    arb_write_addr_i = a; arb_wmask_i = m; arb_wdata_i = d; arb_wsize_i = 4'd2;
    arb_write_valid_i = 1'b1; wr_done = 0;
    for (int c = 0; c < 400 && !wr_done; c++) begin
      @(negedge clk);
      if (arb_wdata_ready_o) wr_done = 1;
    end
    @(posedge clk); #1;
    arb_write_valid_i = 1'b0;
  endtask

  // Reference: byte k of the request lands on bus lane k + addr[1:0]; lanes past 3 are lost.
  function automatic void ref_wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                                 output logic [31:0] ed, output logic [3:0] es);
    int off;
    off = int'(a[1:0]);
    ed = '0; es = '0;
    for (int b = 0; b < 4; b++)
      if (b >= off) begin
        ed[8*b +: 8] = d[8*(b-off) +: 8];
        es[b]        = m[b-off];
      end
  endfunction

  function automatic logic all_out_or();
    return |{arb_rdata_o, arb_rdata_ready_o, arb_rlast_o, arb_wdata_ready_o, resp_err_o,
             araddr, arvalid, arlen, arsize, rready, awaddr, awvalid, awlen, awsize,
             wdata, wstrb, wlast, wvalid, bready};
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    int          aw_lat;
    int          w_lat;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
  } wvec_t;

  wvec_t wv [6];

  initial begin
    int          v0, p0, b0, ok;
    logic [31:0] a, d, ed;
    logic [3:0]  m, es;
    logic [7:0]  len;

    wv[0] = '{32'h8000_0003, 4'h1, 32'h0000_00AB, 0, 2, 32'hAB00_0000, 4'h8};
    wv[1] = '{32'h8000_0000, 4'hF, 32'h1234_5678, 2, 0, 32'h1234_5678, 4'hF};
    wv[2] = '{32'h8000_0002, 4'h3, 32'h0000_BEEF, 0, 0, 32'hBEEF_0000, 4'hC};
    wv[3] = '{32'h8000_0001, 4'h1, 32'h0000_005A, 1, 3, 32'h0000_5A00, 4'h2};
    wv[4] = '{32'h8000_0001, 4'h3, 32'h0000_1234, 3, 1, 32'h0012_3400, 4'h6};
    wv[5] = '{32'h8000_0002, 4'hF, 32'h1122_3344, 1, 1, 32'h3344_0000, 4'hC};

    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", all_out_or(), 0);
    chk("const_burst_id", {arburst, awburst, arid, awid}, {2'b01, 2'b01, 4'd0, 4'd0});
    @(posedge clk); #1; rst = 1'b0;

    // Single read with a 3-cycle AR stall.
    ar_lat = 3; rbase = 32'hDEAD_BEEF; v0 = ar_vcyc;
    do_read(32'h8000_0000, 8'd0);
    chk("single_rd_done", rd_done, 1);
    chk("single_rd_beats", rd_n, 1);
    chk("single_rd_data", rd_buf[0], 32'hDEAD_BEEF);
    chk("single_rd_last_same_beat", rd_last_at, 0);
    chk("single_ar_hold", ar_vcyc - v0, 4);
    chk("single_ar_stable", ar_unstable, 0);
    chk("single_ar_fields", {hs_araddr, hs_arlen, hs_arsize}, {32'h8000_0000, 8'd0, 3'd2});

    // Burst read with rvalid gaps.
    ar_lat = 0; rbase = 32'h0; r_gap_pct = 50;
    do_read(32'h8000_0010, 8'd3);
    chk("burst_rd_beats", rd_n, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("burst_rd_data%0d", i), rd_buf[i], 32'(i));
    chk("burst_rd_last", rd_last_at, 3);
    chk("burst_rd_idle", {arvalid, rready}, 2'b00);
    r_gap_pct = 0;

    // Write alignment / handshake ordering table.
    for (int i = 0; i < 6; i++) begin
      aw_lat = wv[i].aw_lat; w_lat = wv[i].w_lat; p0 = wr_pulse_cnt; b0 = b_hs;
      do_write(wv[i].addr, wv[i].mask, wv[i].data);
      chk($sformatf("wv%0d_done", i), wr_done, 1);
      chk($sformatf("wv%0d_wdata", i), cap_wdata, wv[i].exp_wdata);
      chk($sformatf("wv%0d_wstrb", i), cap_wstrb, wv[i].exp_wstrb);
      chk($sformatf("wv%0d_aw", i), {cap_awaddr, cap_awsize, cap_awlen, cap_wlast},
          {wv[i].addr, 3'd2, 8'd0, 1'b1});
      chk($sformatf("wv%0d_one_pulse", i), wr_pulse_cnt - p0, 1);
      chk($sformatf("wv%0d_one_b", i), b_hs - b0, 1);
    end

    // Concurrent read and write.
    aw_lat = 1; w_lat = 2; ar_lat = 1; rbase = 32'h100;
    fork
      do_read(32'h8000_0100, 8'd1);
      do_write(32'h8000_0200, 4'hF, 32'hCAFE_F00D);
    join
    chk("conc_rd_done", rd_done, 1);
    chk("conc_rd_beats", rd_n, 2);
    chk("conc_rd_data", {rd_buf[0], rd_buf[1]}, {32'h100, 32'h101});
    chk("conc_wr_done", wr_done, 1);
    chk("conc_wr_data", {cap_wdata, cap_wstrb}, {32'hCAFE_F00D, 4'hF});

    // Randomized traffic.
    for (int it = 0; it < 24; it++) begin
      ar_lat = $urandom_range(0, 3); aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3);
      b_lat = $urandom_range(0, 3); r_gap_pct = $urandom_range(0, 60);
      a = $urandom();
      if ($urandom_range(0, 1) == 1) begin
        len = 8'($urandom_range(0, 7)); rbase = $urandom();
        do_read(a, len);
        chk("rnd_rd_beats", rd_n, int'(len) + 1);
        ok = 1;
        for (int i = 0; i < rd_n; i++) if (rd_buf[i] !== rbase + 32'(i)) ok = 0;
        chk("rnd_rd_data", ok, 1);
        chk("rnd_rd_last", rd_last_at, int'(len));
        chk("rnd_rd_addr", {hs_araddr, hs_arlen}, {a, len});
      end else begin
        m = 4'($urandom_range(1, 15)); d = $urandom();
        ref_wr(a, m, d, ed, es);
        do_write(a, m, d);
        chk("rnd_wr_done", wr_done, 1);
        chk("rnd_wr_lanes", {cap_awaddr, cap_wdata, cap_wstrb}, {a, ed, es});
      end
    end
    chk("rnd_ar_stable", ar_unstable, 0);
    chk("err_clean_so_far", resp_err_o, 0);
    ar_lat = 0; aw_lat = 0; w_lat = 0; b_lat = 0; r_gap_pct = 0;

    // Error BRESP is sticky.
    bresp_val = 2'b10;
    do_write(32'h8000_0300, 4'hF, 32'h1);
    bresp_val = 2'b00;
    chk("bresp_err_set", resp_err_o, 1);
    rbase = 32'h0;
    do_read(32'h8000_0400, 8'd0);
    chk("bresp_err_sticky", resp_err_o, 1);

    // Reset while in the data phase of a stalled read.
    r_gap_pct = 100;
    @(posedge clk); #1;
    arb_read_addr_i = 32'h8000_0500; arb_rlen_i = 8'd3; arb_raddr_valid_i = 1'b1;
    ok = 0;
    for (int c = 0; c < 50 && !ok; c++) begin @(negedge clk); if (rready) ok = 1; end
    chk("rst_mid_rd_reached_data", ok, 1);
    @(posedge clk); #1; rst = 1'b1; arb_raddr_valid_i = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_mid_rd_outputs_zero", all_out_or(), 0);
    chk("rst_clears_err", resp_err_o, 0);
    @(posedge clk); #1; rst = 1'b0; r_gap_pct = 0;

    // Slave rlast arrives before the count: burst ends early and flags an error.
    rlast_off = -1; rbase = 32'h40;
    do_read(32'h8000_0600, 8'd2);
    rlast_off = 0;
    chk("early_rlast_beats", rd_n, 2);
    chk("early_rlast_last", rd_last_at, 1);
    chk("early_rlast_err", resp_err_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
